// File: rtl/mem_port_pkg.sv
// Shared definitions for the memory-side command port: opcodes, unit IDs,
// FSM states and command-byte field positions.
package mem_port_pkg;

  typedef enum logic [1:0] {
    OP_RD_KEY  = 2'b00,
    OP_RD_TEXT = 2'b01,
    OP_WR_RES  = 2'b10,
    OP_OTHER   = 2'b11
  } opcode_e;

  localparam logic [1:0] ID_MEM = 2'b00;
  localparam logic [1:0] ID_SHA = 2'b01;
  localparam logic [1:0] ID_AES = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_XFER,
    ST_ACK_REQ,
    ST_ACK_DONE
  } state_e;

  localparam int CMD_ENC_BIT  = 7;
  localparam int CMD_DEST_LSB = 4;
  localparam int CMD_SRC_LSB  = 2;
  localparam int CMD_OP_LSB   = 0;

  // Reads are addressed by destination, result writes by source.
  function automatic logic cmd_targets(input logic [7:0] cmd, input logic [1:0] id);
    case (cmd[CMD_OP_LSB +: 2])
      OP_RD_KEY, OP_RD_TEXT: return cmd[CMD_DEST_LSB +: 2] == id;
      OP_WR_RES:             return cmd[CMD_SRC_LSB +: 2] == id;
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_cmd_port_buffered_fifo.sv
// First-word-fall-through FIFO with registered storage; the head is the
// entry at the read pointer, so a pushed word appears one cycle later.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mem_cmd_port_buffered.sv
// Memory-side command port: decodes a command, captures the address, moves
// payload through a shared FIFO and acks completed reads; stall watchdog.
module mem_cmd_port_buffered
  import mem_port_pkg::*;
#(
  parameter int         ADDR_BYTES = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 256,
  parameter logic [1:0] MEM_ID     = ID_MEM
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_bus_valid,
  input  logic [7:0]              in_bus_data,
  output logic                    out_bus_ready,
  output logic                    out_bus_valid,
  output logic [7:0]              out_bus_data,
  input  logic                    in_bus_ready,
  output logic                    out_ack_req,
  output logic [1:0]              out_ack_id,
  input  logic                    in_ack_grant,
  output logic                    out_cmd_start,
  output logic [1:0]              out_opcode,
  output logic                    out_enc_type,
  output logic [8*ADDR_BYTES-1:0] out_address,
  output logic                    out_fsm_valid,
  output logic [7:0]              out_fsm_data,
  input  logic                    in_fsm_ready,
  input  logic                    in_fsm_valid,
  input  logic [7:0]              in_fsm_data,
  output logic                    out_fsm_ready,
  input  logic                    in_fsm_done,
  output logic [15:0]             out_xfer_count,
  output logic                    out_error
);

  localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    live_q;
  logic [1:0]              opcode_q;
  logic                    enc_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [1:0]              addr_idx_q;
  logic [15:0]             count_q;
  logic                    done_q, cmd_start_q, error_q;
  logic [WD_W-1:0]         wd_q;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]              fifo_wdata, fifo_rdata;
  logic                    is_wr, in_xfer, cmd_hit, addr_last, bus_hs, wd_hit;

  assign is_wr     = (opcode_q == OP_WR_RES);
  assign in_xfer   = (state_q == ST_XFER);
  assign cmd_hit   = cmd_targets(in_bus_data, MEM_ID);
  assign addr_last = (addr_idx_q == 2'(ADDR_BYTES - 1));
  assign bus_hs    = in_bus_valid && out_bus_ready;
  assign wd_hit    = (TIMEOUT != 0) && in_xfer && (wd_q == WD_LAST) && !fifo_push && !fifo_pop;

  // The latched opcode decides which side feeds and which side drains the FIFO.
  always_comb begin
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_wdata = in_bus_data;
    if (in_xfer) begin
      if (is_wr) begin
        fifo_push = in_bus_valid && !fifo_full;
        fifo_pop  = in_fsm_ready && !fifo_empty;
      end else begin
        fifo_push  = in_fsm_valid && !fifo_full;
        fifo_pop   = in_bus_ready && !fifo_empty;
        fifo_wdata = in_fsm_data;
      end
    end
  end

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (wd_hit),
    .push    (fifo_push),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus_hs && cmd_hit) state_d = ST_ADDR;
      ST_ADDR:     if (bus_hs && addr_last) state_d = ST_XFER;
      ST_XFER: begin
        if (wd_hit) state_d = ST_IDLE;
        else if (done_q && fifo_empty && is_wr) state_d = ST_IDLE;
        else if (done_q && fifo_empty && !in_fsm_valid) state_d = ST_ACK_REQ;
      end
      ST_ACK_REQ:  if (in_ack_grant) state_d = ST_ACK_DONE;
      ST_ACK_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_bus_ready = 1'b0;
    out_bus_valid = 1'b0;
    out_fsm_valid = 1'b0;
    out_fsm_ready = 1'b0;
    out_ack_req   = 1'b0;
    out_ack_id    = 2'b00;
    case (state_q)
      ST_IDLE, ST_ADDR: out_bus_ready = live_q;
      ST_XFER: begin
        out_bus_ready = is_wr && !fifo_full;
        out_fsm_valid = is_wr && !fifo_empty;
        out_fsm_ready = !is_wr && !fifo_full;
        out_bus_valid = !is_wr && !fifo_empty;
      end
      ST_ACK_REQ: begin
        out_ack_req = 1'b1;
        out_ack_id  = MEM_ID;
      end
      default: ;
    endcase
    out_bus_data = out_bus_valid ? fifo_rdata : 8'h00;
    out_fsm_data = out_fsm_valid ? fifo_rdata : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      enc_q       <= 1'b0;
      addr_q      <= '0;
      addr_idx_q  <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      cmd_start_q <= 1'b0;
      error_q     <= 1'b0;
      wd_q        <= '0;
    end else begin
      cmd_start_q <= (state_q == ST_ADDR) && bus_hs && addr_last;
      error_q     <= wd_hit;
      if (state_q == ST_IDLE && bus_hs && cmd_hit) begin
        opcode_q   <= in_bus_data[CMD_OP_LSB +: 2];
        enc_q      <= in_bus_data[CMD_ENC_BIT];
        addr_q     <= '0;
        addr_idx_q <= '0;
        count_q    <= '0;
      end else if (state_q == ST_ADDR && bus_hs) begin
        for (int k = 0; k < ADDR_BYTES; k++)
          if (addr_idx_q == 2'(k)) addr_q[8*k +: 8] <= in_bus_data;
        addr_idx_q <= addr_idx_q + 2'd1;
      end else if (fifo_pop && count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
      // A done pulse that arrives while the address is still coming in is kept.
      if (state_q == ST_IDLE) done_q <= 1'b0;
      else if (in_fsm_done)   done_q <= 1'b1;
      if (!in_xfer || fifo_push || fifo_pop) wd_q <= '0;
      else                                   wd_q <= wd_q + 1'b1;
    end
  end

  assign out_cmd_start  = cmd_start_q;
  assign out_opcode     = opcode_q;
  assign out_enc_type   = enc_q;
  assign out_address    = addr_q;
  assign out_xfer_count = count_q;
  assign out_error      = error_q;

endmodule

// File: tb/tb_mem_cmd_port_buffered.sv
// Bench for mem_cmd_port_buffered: command-decode table plus scoreboarded
// write/read, backpressure, watchdog and reset sequences.
module tb_mem_cmd_port_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_bus_valid, in_bus_ready, in_ack_grant;
  logic [7:0]  in_bus_data, in_fsm_data;
  logic        in_fsm_ready, in_fsm_valid, in_fsm_done;
  logic        out_bus_ready, out_bus_valid, out_ack_req, out_cmd_start;
  logic        out_enc_type, out_fsm_valid, out_fsm_ready, out_error;
  logic [7:0]  out_bus_data, out_fsm_data;
  logic [1:0]  out_ack_id, out_opcode;
  logic [23:0] out_address;
  logic [15:0] out_xfer_count;

  mem_cmd_port_buffered #(.ADDR_BYTES(3), .FIFO_DEPTH(4), .TIMEOUT(16), .MEM_ID(2'b00)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_bus_valid(in_bus_valid), .in_bus_data(in_bus_data), .out_bus_ready(out_bus_ready),
    .out_bus_valid(out_bus_valid), .out_bus_data(out_bus_data), .in_bus_ready(in_bus_ready),
    .out_ack_req(out_ack_req), .out_ack_id(out_ack_id), .in_ack_grant(in_ack_grant),
    .out_cmd_start(out_cmd_start), .out_opcode(out_opcode), .out_enc_type(out_enc_type),
    .out_address(out_address), .out_fsm_valid(out_fsm_valid), .out_fsm_data(out_fsm_data),
    .in_fsm_ready(in_fsm_ready), .in_fsm_valid(in_fsm_valid), .in_fsm_data(in_fsm_data),
    .out_fsm_ready(out_fsm_ready), .in_fsm_done(in_fsm_done), .out_xfer_count(out_xfer_count),
    .out_error(out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    bit         accept;
    logic [1:0] op;
    logic       enc;
  } dec_vec_t;

  int         checks = 0, errors = 0;
  int         cyc = 0, n_start = 0, n_err = 0, n_ack = 0, cyc_start = 0, cyc_err = 0;
  logic [7:0] exp_fsm[$];
  logic [7:0] exp_bus[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: every payload byte leaving the port is matched in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_fsm_valid && in_fsm_ready) begin
        if (exp_fsm.size() == 0) check("fsm_unexpected", {24'd0, out_fsm_data}, 32'hFFFF_FFFF);
        else check("fsm_data", {24'd0, out_fsm_data}, {24'd0, exp_fsm.pop_front()});
      end
      if (out_bus_valid && in_bus_ready) begin
        if (exp_bus.size() == 0) check("bus_unexpected", {24'd0, out_bus_data}, 32'hFFFF_FFFF);
        else check("bus_data", {24'd0, out_bus_data}, {24'd0, exp_bus.pop_front()});
      end
      if (out_cmd_start) begin n_start++; cyc_start = cyc; end
      if (out_error)     begin n_err++;   cyc_err   = cyc; end
      if (out_ack_req)   n_ack++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_send(input logic [7:0] b, input bit track, output int waits);
    bit ok = 0;
    in_bus_valid = 1'b1;
    in_bus_data  = b;
    waits = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_bus_ready) begin ok = 1; break; end
      waits++;
    end
    if (!ok) fail("bus_send");
    @(posedge clk); #1;
    in_bus_valid = 1'b0;
    if (ok && track) exp_fsm.push_back(b);
  endtask

  task automatic fsm_send(input logic [7:0] b);
    bit ok = 0;
    in_fsm_valid = 1'b1;
    in_fsm_data  = b;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_fsm_ready) begin ok = 1; break; end
    end
    if (!ok) fail("fsm_send");
    @(posedge clk); #1;
    in_fsm_valid = 1'b0;
    if (ok) exp_bus.push_back(b);
  endtask

  task automatic do_cmd(input logic [7:0] cmd);
    int w;
    bus_send(cmd, 0, w);
    bus_send(8'h10, 0, w);
    bus_send(8'h20, 0, w);
    bus_send(8'h30, 0, w);
  endtask

  task automatic pulse_done();
    in_fsm_done = 1'b1;
    cycles(1);
    in_fsm_done = 1'b0;
  endtask

  task automatic wait_err();
    int e0 = n_err;
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      cycles(1);
      if (n_err != e0) begin ok = 1; break; end
    end
    if (!ok) fail("wait_error");
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (exp_bus.size() == 0 && exp_fsm.size() == 0) begin ok = 1; break; end
      cycles(1);
    end
    if (!ok) fail(name);
  endtask

  task automatic wait_ack();
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (out_ack_req) begin ok = 1; break; end
      cycles(1);
    end
    if (!ok) fail("wait_ack");
  endtask

  task automatic finish_read();
    wait_drain("rd_drain");
    pulse_done();
    wait_ack();
    in_ack_grant = 1'b1;
    cycles(1);
    in_ack_grant = 1'b0;
    cycles(2);
  endtask

  function automatic logic [31:0] ctl_bits();
    return {4'd0, out_bus_ready, out_bus_valid, out_bus_data, out_ack_req, out_ack_id,
            out_cmd_start, out_opcode, out_enc_type, out_fsm_valid, out_fsm_data,
            out_fsm_ready, out_error};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    dec_vec_t   vecs[8];
    int         w, s0, a0, stalls;
    logic [1:0] last_op;
    logic       last_enc;

    vecs[0] = '{8'h13, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{8'h10, 1'b0, 2'b00, 1'b0};
    vecs[2] = '{8'h86, 1'b0, 2'b00, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 2'b01, 1'b0};
    vecs[4] = '{8'h8E, 1'b0, 2'b00, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 2'b01, 1'b1};
    vecs[6] = '{8'h42, 1'b1, 2'b10, 1'b0};
    vecs[7] = '{8'h21, 1'b0, 2'b00, 1'b0};

    rst_n = 1'b0;
    in_bus_valid = 0; in_bus_data = 0; in_bus_ready = 0; in_ack_grant = 0;
    in_fsm_ready = 0; in_fsm_valid = 0; in_fsm_data = 0; in_fsm_done = 0;
    cycles(3);
    check("reset_ctl", ctl_bits(), 32'd0);
    check("reset_addr", {8'd0, out_address}, 32'd0);
    check("reset_count", {16'd0, out_xfer_count}, 32'd0);
    rst_n = 1'b1;
    cycles(1);

    // Write: address capture, payload to FSM in order, silent completion.
    in_fsm_ready = 1'b1;
    s0 = n_start; a0 = n_ack;
    do_cmd(8'h82);
    check("wr_cmd_start", {31'd0, out_cmd_start}, 32'd1);
    check("wr_address", {8'd0, out_address}, 32'h0030_2010);
    check("wr_enc_type", {31'd0, out_enc_type}, 32'd1);
    check("wr_opcode", {30'd0, out_opcode}, 32'd2);
    for (int i = 0; i < 4; i++) bus_send(8'hA1 + 8'(i), 1, w);
    wait_drain("wr_drain");
    pulse_done();
    cycles(2);
    check("wr_start_once", n_start - s0, 32'd1);
    check("wr_no_ack", n_ack - a0, 32'd0);
    check("wr_count", {16'd0, out_xfer_count}, 32'd4);

    // Read with the bus stalled: FIFO fills, then drains in order, then ack.
    in_fsm_ready = 1'b0;
    in_bus_ready = 1'b0;
    do_cmd(8'h00);
    for (int i = 0; i < 4; i++) fsm_send(8'h60 + 8'(i));
    check("rd_fsm_ready_full", {31'd0, out_fsm_ready}, 32'd0);
    in_fsm_valid = 1'b1;
    in_fsm_data  = 8'h64;
    cycles(6);
    check("rd_fsm_ready_held", {31'd0, out_fsm_ready}, 32'd0);
    check("rd_bus_valid", {31'd0, out_bus_valid}, 32'd1);
    in_bus_ready = 1'b1;
    fsm_send(8'h64);
    fsm_send(8'h65);
    wait_drain("rd_drain");
    pulse_done();
    wait_ack();
    cycles(3);
    check("rd_ack_held", {31'd0, out_ack_req}, 32'd1);
    check("rd_ack_id", {30'd0, out_ack_id}, 32'd0);
    in_ack_grant = 1'b1;
    cycles(1);
    in_ack_grant = 1'b0;
    check("rd_ack_dropped", {31'd0, out_ack_req}, 32'd0);
    check("rd_ack_done_busy", {31'd0, out_bus_ready}, 32'd0);
    cycles(1);
    check("rd_idle_after_grant", {31'd0, out_bus_ready}, 32'd1);
    check("rd_count", {16'd0, out_xfer_count}, 32'd6);

    // Command decode table; accepted commands are left to the watchdog.
    in_bus_ready = 1'b0;
    last_op = 2'b00; last_enc = 1'b0;
    foreach (vecs[i]) begin
      do_cmd(vecs[i].cmd);
      check($sformatf("dec_start_%02h", vecs[i].cmd), {31'd0, out_cmd_start}, {31'd0, vecs[i].accept});
      if (vecs[i].accept) begin
        last_op = vecs[i].op;
        last_enc = vecs[i].enc;
        check($sformatf("dec_addr_%02h", vecs[i].cmd), {8'd0, out_address}, 32'h0030_2010);
        wait_err();
      end else begin
        cycles(1);
      end
      check($sformatf("dec_op_%02h", vecs[i].cmd), {29'd0, last_enc, last_op},
            {29'd0, out_enc_type, out_opcode});
    end

    // Watchdog latency with a silent FSM, then abort with data buffered.
    do_cmd(8'h01);
    wait_err();
    check("wd_latency", cyc_err - cyc_start, 32'd16);
    check("wd_idle", {31'd0, out_fsm_ready}, 32'd0);
    do_cmd(8'h00);
    fsm_send(8'h71);
    fsm_send(8'h72);
    wait_err();
    exp_bus.delete();
    in_bus_ready = 1'b1;
    cycles(2);
    check("wd_flushed", {31'd0, out_bus_valid}, 32'd0);
    a0 = n_ack;
    do_cmd(8'h01);
    check("wd_next_cmd", {31'd0, out_cmd_start}, 32'd1);
    fsm_send(8'h5A);
    finish_read();
    check("wd_next_ack", {31'd0, (n_ack != a0)}, 32'd1);

    // Full FIFO, then concurrent push and pop with no stalls.
    in_fsm_ready = 1'b0;
    do_cmd(8'h82);
    for (int i = 0; i < 4; i++) bus_send(8'hB0 + 8'(i), 1, w);
    check("full_bus_ready", {31'd0, out_bus_ready}, 32'd0);
    in_fsm_ready = 1'b1;
    stalls = 0;
    for (int i = 4; i < 20; i++) begin
      bus_send(8'hB0 + 8'(i), 1, w);
      if (i > 4) stalls += w;
    end
    check("full_no_stall", stalls, 32'd0);
    wait_drain("full_drain");
    pulse_done();
    cycles(2);
    check("full_count", {16'd0, out_xfer_count}, 32'd20);

    // Reset in the middle of a buffered read.
    in_fsm_ready = 1'b0;
    in_bus_ready = 1'b0;
    do_cmd(8'h00);
    for (int i = 0; i < 3; i++) fsm_send(8'hD0 + 8'(i));
    check("pre_reset_valid", {31'd0, out_bus_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", ctl_bits(), 32'd0);
    check("midrst_addr", {8'd0, out_address}, 32'd0);
    check("midrst_count", {16'd0, out_xfer_count}, 32'd0);
    exp_bus.delete();
    cycles(2);
    rst_n = 1'b1;
    in_bus_ready = 1'b1;
    a0 = n_ack;
    do_cmd(8'h01);
    check("post_rst_start", {31'd0, out_cmd_start}, 32'd1);
    fsm_send(8'hC1);
    fsm_send(8'hC2);
    finish_read();
    check("post_rst_count", {16'd0, out_xfer_count}, 32'd2);
    check("post_rst_ack", {31'd0, (n_ack != a0)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
